// File: rtl/huffman_dec.sv
// Serial decoder for the six-symbol gray-level Huffman code: latches the code table once, then turns a bit stream into symbols 1..6.
// Optional per-symbol decoded counters DCNT1..DCNT6 are built when HUFFMAN_DEC_HIST_EN is defined.
module huffman_dec #(
  parameter int NUM_SYM = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       bit_ready,
  output logic       sym_valid,
  output logic [7:0] sym_data,
`ifdef HUFFMAN_DEC_HIST_EN
  output logic [7:0] DCNT1,
  output logic [7:0] DCNT2,
  output logic [7:0] DCNT3,
  output logic [7:0] DCNT4,
  output logic [7:0] DCNT5,
  output logic [7:0] DCNT6,
`endif
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [7:0] NUM_SYM_C = 8'(NUM_SYM);

  // Code length is the position of the mask's top set bit; an empty mask disables the entry.
  function automatic logic [3:0] mask_len(input logic [7:0] m);
    logic [3:0] len;
    len = 4'd0;
    for (int i = 0; i < 8; i++) begin
      len = m[i] ? 4'(i + 1) : len;
    end
    return len;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sym_cnt_q, sym_cnt_d;
  logic [7:0] hc_q [6];
  logic [7:0] hc_d [6];
  logic [7:0] m_q  [6];
  logic [7:0] m_d  [6];
  logic       sym_valid_q, sym_valid_d;
  logic [7:0] sym_data_q, sym_data_d;

  logic [7:0] hc_in [6];
  logic [7:0] m_in  [6];
  logic [3:0] len_s [6];
  logic [7:0] nacc_s;
  logic [3:0] ncnt_s;
  logic [5:0] match_s;
  logic       hit_s;
  logic [2:0] hit_idx_s;
  logic       accept_s;

  assign hc_in[0] = HC1;
  assign hc_in[1] = HC2;
  assign hc_in[2] = HC3;
  assign hc_in[3] = HC4;
  assign hc_in[4] = HC5;
  assign hc_in[5] = HC6;
  assign m_in[0]  = M1;
  assign m_in[1]  = M2;
  assign m_in[2]  = M3;
  assign m_in[3]  = M4;
  assign m_in[4]  = M5;
  assign m_in[5]  = M6;

  assign nacc_s   = (acc_q << 1) | {7'd0, bit_in};
  assign ncnt_s   = cnt_q + 4'd1;
  assign accept_s = (state_q == S_RUN) && bit_valid;

  always_comb begin
    match_s = 6'd0;
    for (int k = 0; k < 6; k++) begin
      len_s[k]   = mask_len(m_q[k]);
      match_s[k] = (len_s[k] == ncnt_s) && ((nacc_s & m_q[k]) == (hc_q[k] & m_q[k]));
    end
  end

  // Lowest matching entry wins if a malformed table produces a tie.
  always_comb begin
    hit_idx_s = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      hit_idx_s = match_s[k] ? 3'(k) : hit_idx_s;
    end
  end

  assign hit_s = |match_s;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sym_cnt_d   = sym_cnt_q;
    hc_d        = hc_q;
    m_d         = m_q;
    sym_valid_d = 1'b0;
    sym_data_d  = sym_data_q;
    case (state_q)
      S_IDLE: begin
        if (code_valid) begin
          hc_d    = hc_in;
          m_d     = m_in;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!bit_valid) begin
          state_d = S_RUN;
        end else if (hit_s) begin
          sym_valid_d = 1'b1;
          sym_data_d  = {5'd0, hit_idx_s} + 8'd1;
          acc_d       = 8'd0;
          cnt_d       = 4'd0;
          sym_cnt_d   = sym_cnt_q + 8'd1;
          state_d     = (sym_cnt_d == NUM_SYM_C) ? S_DONE : S_RUN;
        end else if (ncnt_s == 4'd8) begin
          state_d = S_ERR;
        end else begin
          acc_d = nacc_s;
          cnt_d = ncnt_s;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= 8'd0;
      cnt_q       <= 4'd0;
      sym_cnt_q   <= 8'd0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= 8'd0;
      for (int k = 0; k < 6; k++) begin
        hc_q[k] <= 8'd0;
        m_q[k]  <= 8'd0;
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      hc_q        <= hc_d;
      m_q         <= m_d;
    end
  end

  assign bit_ready = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;

`ifdef HUFFMAN_DEC_HIST_EN
  logic [7:0] dcnt_q [6];

  // Saturating per-symbol counters, updated on the same edge that raises sym_valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (reset) begin
        dcnt_q[k] <= 8'd0;
      end else if (accept_s && hit_s && (hit_idx_s == 3'(k)) && (dcnt_q[k] != 8'hFF)) begin
        dcnt_q[k] <= dcnt_q[k] + 8'd1;
      end else begin
        dcnt_q[k] <= dcnt_q[k];
      end
    end
  end

  assign DCNT1 = dcnt_q[0];
  assign DCNT2 = dcnt_q[1];
  assign DCNT3 = dcnt_q[2];
  assign DCNT4 = dcnt_q[3];
  assign DCNT5 = dcnt_q[4];
  assign DCNT6 = dcnt_q[5];
`endif

endmodule

// File: doc/huffman_dec.md
# huffman_dec

Serial Huffman decoder for the six-symbol gray-level code produced by `huffman`. It latches the code table from `code_valid`/`HC1..HC6`/`M1..M6` once. It then consumes a first-bit-first code bitstream one bit per cycle and emits one decoded gray symbol (1..6) per completed codeword. It sits downstream of the encoder in the same top-level design and closes the loop for self-check of the compressed pixel stream.

## Interface
- `NUM_SYM`, default 100: number of symbols to decode before entering DONE; range 1..255.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `code_valid` input 1: code table valid; level signal, held high by the encoder.
- `HC1..HC6` input 8 each: codeword of symbol k; bit 0 = last-transmitted bit.
- `M1..M6` input 8 each: thermometer mask of symbol k; popcount = code length.
- `bit_valid` input 1: `bit_in` is valid this cycle.
- `bit_in` input 1: next code bit, MSB of codeword first.
- `bit_ready` output 1: decoder accepts a bit this cycle.
- `sym_valid` output 1: one-cycle pulse, `sym_data` valid.
- `sym_data` output 8: decoded gray value 1..6.
- `done` output 1: NUM_SYM symbols decoded; sticky.
- `err` output 1: undecodable bit sequence; sticky.

## Operation
- States: IDLE, RUN, DONE, ERR.
- **IDLE**
  - `bit_ready`=0.
  - First cycle with `code_valid`=1: latch HCk and Mk into table registers, then go to RUN.
  - Compute `len_k` = index of the highest set bit of Mk, plus 1. Mk=0 gives `len_k`=0, which disables the entry.
- **RUN**
  - `bit_ready`=1. A bit is accepted when `bit_valid && bit_ready`.
  - Per accepted bit:
    - `nacc` = {acc[6:0], bit_in}.
    - `ncnt` = cnt+1.
  - Match k when `len_k`==`ncnt` and (`nacc` & Mk)==(HCk & Mk).
  - Ties resolve to the lowest k; a well-formed table never ties.
  - On match:
    - Register `sym_data`=k, `sym_valid`=1.
    - Clear acc and cnt.
    - Increment `sym_cnt`.
    - If the new `sym_cnt`==NUM_SYM, go to DONE.
  - No match and `ncnt`==8: `err`=1, go to ERR.
  - Otherwise: acc=`nacc`, cnt=`ncnt`.
- **DONE**: `bit_ready`=0, `done`=1. Further bits and `code_valid` are ignored.
- **ERR**: `bit_ready`=0, `err`=1. Only `reset` exits.
- The table is never reloaded after IDLE. Table changes on `HC`/`M` while in RUN are ignored.
- Arithmetic widths:
  - acc is 8 bits.
  - cnt is 4 bits.
  - `sym_cnt` is 8 bits and never wraps, because DONE stops it.

## Timing
- Reset, applied on any clock edge with `reset`=1:
  - State IDLE; acc, cnt, `sym_cnt`, and table registers = 0.
  - `bit_ready`=0, `sym_valid`=0, `sym_data`=0, `done`=0, `err`=0.
- Reset mid-decode discards partial codewords and the table.
- Table latch: `code_valid` sampled high at edge N gives `bit_ready`=1 from cycle N+1.
- Decode latency:
  - Final codeword bit accepted at edge N gives `sym_valid`=1 during cycle N+1 only.
  - `sym_data` holds its value until the next match.
- Back-to-back operation: a bit is accepted every cycle in RUN, including the cycle `sym_valid` is high. Throughput is 1 bit/clk.
- Last symbol: `sym_valid` and `done` both rise in the same cycle N+1, and `bit_ready` falls in that cycle.
- Error: the 8th unmatched bit at edge N gives `err`=1 and `bit_ready`=0 from cycle N+1. No `sym_valid` is generated.
- `bit_valid`=0 in RUN holds all state.

## Configuration
- Macro: `HUFFMAN_DEC_HIST_EN`.
- Defined:
  - Adds outputs `DCNT1..DCNT6` (8 bits each): per-symbol decoded counts.
  - Each count increments in the same cycle `sym_valid` rises, saturates at 255, and resets to 0.
  - Intended for direct comparison with `CNT1..CNT6`.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

## Test plan
Table T used below:
- HC = 01,01,01,01,01,00 (hex).
- M = 01,03,07,0F,1F,1F (hex).
- Codes: "1","01","001","0001","00001","00000".

Scenarios:
- **Reset/load**: `reset` 1 cycle, then `code_valid`=1 with T at edge 3 -> all outputs 0 before; `bit_ready`=1 from cycle 4.
- **Basic decode**: after T, stream 1,0,1,0,0,0,0,0 back-to-back -> `sym_valid` pulses with `sym_data`=1, 2, 6, each one cycle after its final bit.
- **Stall**: stream "0001" with `bit_valid` low 3 cycles between bits 2 and 3 -> single `sym_valid`, `sym_data`=4, no spurious pulse.
- **Done**: NUM_SYM=4, send "1" four times -> 4 pulses; `done`=1 with the 4th pulse; `bit_ready`=0 thereafter; extra bits ignored.
- **Error**: table M1=M2=03, HC1=00, HC2=01, M3..M6=00; send eight 1s -> no `sym_valid`; `err`=1 the cycle after the 8th bit; `bit_ready`=0.
- **Histogram** (`HUFFMAN_DEC_HIST_EN`): T, 100 symbols with counts 10,20,30,15,15,10 -> `DCNT1..6` match exactly; `done`=1.
